ntt_io_ctrl: RTL

- Host-side load/unload controller for the NTT/INTT core and its dual-port coefficient RAM.
- Accepts a 256-coefficient polynomial on a valid/ready input stream, reduces each coefficient mod Q, and writes them pairwise into the RAM.
- Pulses the core to run NTT or INTT, waits for done, then streams the 256 results out on a valid/ready output stream.
- Owns the RAM ports except while the core runs.

---
 rtl/ntt_io_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ntt_io_ctrl.sv
// rtl/ntt_io_ctrl.sv - load/unload controller for the NTT/INTT core and its dual-port coefficient RAM
module ntt_io_ctrl #(
    parameter int          N  = 256,
    parameter int          AW = 8,
    parameter int          DW = 24,
    parameter int unsigned Q  = 8380417
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          mode_i,
    input  logic [DW-1:0] s_data_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    output logic [DW-1:0] m_data_o,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic          m_last_o,
    output logic          ram_sel_o,
    output logic          ram_wren_o,
    output logic [AW-1:0] ram_addr1_o,
    output logic [AW-1:0] ram_addr2_o,
    output logic [DW-1:0] ram_wdata1_o,
    output logic [DW-1:0] ram_wdata2_o,
    input  logic [DW-1:0] ram_rdata1_i,
    input  logic [DW-1:0] ram_rdata2_i,
    output logic          core_start_o,
    output logic          core_ntt_o,
    input  logic          core_done_i,
    output logic          busy_o
);

    localparam int            KW       = AW - 1;
    localparam logic [DW-1:0] Q_W      = DW'(Q);
    localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(N / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_READ,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q;
    logic [DW-1:0] hold_q;
    logic [KW-1:0] k_q;
    logic          inflight_q;
    logic [DW-1:0] fifo_q [4];
    logic [1:0]    wp_q, rp_q;
    logic [2:0]    cnt_q;
    logic [AW-1:0] out_idx_q;

    logic [DW-1:0] red1, red;
    logic          accept, rd_issue, pop, push, rd_room;
    logic [1:0]    wp_nx;

    // Two conditional subtractions cover every 24-bit input since 2^24 < 3Q.
    assign red1 = (s_data_i >= Q_W) ? s_data_i - Q_W : s_data_i;
    assign red  = (red1 >= Q_W) ? red1 - Q_W : red1;

    assign m_valid_o = (cnt_q != 3'd0);
    assign m_data_o  = fifo_q[rp_q];
    assign m_last_o  = m_valid_o && (out_idx_q == IDX_LAST);
    assign pop       = m_valid_o && m_ready_i;
    assign push      = inflight_q;
    assign wp_nx     = wp_q + 2'd1;
    assign accept    = s_valid_i && s_ready_o;
    // A new pair is only issued if both its words are guaranteed a FIFO slot.
    assign rd_room   = (cnt_q + {1'b0, inflight_q, 1'b0}) <= 3'd2;

    always_comb begin
        state_d      = state_q;
        s_ready_o    = 1'b0;
        ram_sel_o    = 1'b1;
        ram_wren_o   = 1'b0;
        ram_addr1_o  = '0;
        ram_addr2_o  = '0;
        ram_wdata1_o = '0;
        ram_wdata2_o = '0;
        core_start_o = 1'b0;
        busy_o       = 1'b1;
        rd_issue     = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_o    = 1'b0;
                s_ready_o = 1'b1;
                if (s_valid_i) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                s_ready_o = 1'b1;
                if (s_valid_i && idx_q[0]) begin
                    ram_wren_o   = 1'b1;
                    ram_addr1_o  = {idx_q[AW-1:1], 1'b0};
                    ram_addr2_o  = idx_q;
                    ram_wdata1_o = hold_q;
                    ram_wdata2_o = red;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                ram_sel_o    = 1'b0;
                core_start_o = 1'b1;
                state_d      = S_RUN;
            end
            S_RUN: begin
                ram_sel_o = 1'b0;
                if (core_done_i) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (rd_room) begin
                    rd_issue    = 1'b1;
                    ram_addr1_o = {k_q, 1'b0};
                    ram_addr2_o = {k_q, 1'b1};
                    if (k_q == K_LAST) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && out_idx_q == IDX_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            hold_q     <= '0;
            core_ntt_o <= 1'b0;
            k_q        <= '0;
            inflight_q <= 1'b0;
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            out_idx_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;

            if (accept) begin
                if (state_q == S_IDLE) begin
                    core_ntt_o <= mode_i;
                    hold_q     <= red;
                    idx_q      <= AW'(1);
                end else begin
                    if (!idx_q[0]) begin
                        hold_q <= red;
                    end
                    idx_q <= idx_q + AW'(1);
                end
            end

            if (state_q == S_RUN && core_done_i) begin
                k_q       <= '0;
                out_idx_q <= '0;
            end else begin
                if (rd_issue) begin
                    k_q <= k_q + KW'(1);
                end
                if (pop) begin
                    out_idx_q <= out_idx_q + AW'(1);
                end
            end

            inflight_q <= rd_issue;

            // Read data returns one cycle after the address; even word goes in first.
            if (push) begin
                fifo_q[wp_q]  <= ram_rdata1_i;
                fifo_q[wp_nx] <= ram_rdata2_i;
                wp_q          <= wp_q + 2'd2;
            end
            if (pop) begin
                rp_q <= rp_q + 2'd1;
            end
            cnt_q <= cnt_q + (push ? 3'd2 : 3'd0) - (pop ? 3'd1 : 3'd0);
        end
    end

endmodule
